// File: rtl/sync_fifo_prog_if.sv
// Handshake/status bundle for sync_fifo_prog.
// Master drives write/read requests, flush and the programmable levels.
// Slave (the FIFO) returns data, occupancy, status flags and handshake pulses.
interface sync_fifo_prog_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
);
  logic                  flush;
  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [CNT_W-1:0]      af_level;
  logic [CNT_W-1:0]      ae_level;
  logic [FIFO_WIDTH-1:0] data_out;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  almostfull;
  logic                  empty;
  logic                  almostempty;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, data_in, rd_en, af_level, ae_level,
    input  data_out, count, full, almostfull, empty, almostempty,
           wr_ack, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en, af_level, ae_level,
    output data_out, count, full, almostfull, empty, almostempty,
           wr_ack, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO, arbitrary depth, programmable almost-full/empty, flush, std/FWFT read.
// Latency: write visible to reads 1 cycle after the write edge; std read data 1 cycle after rd_en edge.
// Backpressure: writes refused when full unless a read is accepted the same cycle; reads refused when empty.
// Ports: clk/rst_n plain; bus (slave modport) carries flush, wr_en/data_in, rd_en,
//   af_level/ae_level in and data_out, count, full/almostfull/empty/almostempty,
//   wr_ack/overflow/underflow (registered one-cycle pulses) out.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter bit FWFT       = 1'b0,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_fifo_prog_if.slave bus
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ack_q, wr_ack_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic full, empty, wr_acc, rd_acc, mem_we;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  // Read acceptance only looks at registered occupancy: no write-to-read bypass.
  assign rd_acc = bus.rd_en & ~empty;
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wr_acc = bus.wr_en & (~full | rd_acc);
  assign mem_we = wr_acc & ~bus.flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_acc;
    overflow_d  = bus.wr_en & ~wr_acc;
    underflow_d = bus.rd_en & ~rd_acc;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      wr_ack_d    = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: pointers/count define which entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= bus.data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.data_out = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   dout_q <= '0;
        else if (rd_acc && !bus.flush) dout_q <= mem_q[rd_ptr_q];
      end
      assign bus.data_out = dout_q;
    end
  endgenerate

  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count_q >= bus.af_level) & ~full;
  assign bus.almostempty = (count_q <= bus.ae_level) & ~empty;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;
  localparam int W = 16;
  localparam int D = 6;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [CW-1:0] af_level = CW'(5);
  logic [CW-1:0] ae_level = CW'(1);

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_prog_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) b0 ();
  sync_fifo_prog_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) b1 ();

  assign b0.flush = flush;  assign b1.flush = flush;
  assign b0.wr_en = wr_en;  assign b1.wr_en = wr_en;
  assign b0.rd_en = rd_en;  assign b1.rd_en = rd_en;
  assign b0.data_in = data_in;  assign b1.data_in = data_in;
  assign b0.af_level = af_level;  assign b1.af_level = af_level;
  assign b0.ae_level = ae_level;  assign b1.ae_level = ae_level;

  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents as an ordered queue, std read data as a held word.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout;
  logic m_ack, m_ovf, m_udf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_dout = '0;
      m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      bit rd, wr;
      rd = rd_en && (mq.size() > 0);
      wr = wr_en && ((mq.size() < D) || rd);
      m_ack = wr;
      m_ovf = wr_en && !wr;
      m_udf = rd_en && !rd;
      if (rd) m_dout = mq.pop_front();
      if (wr) mq.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    int n;
    logic e_full, e_empty, e_af, e_ae;
    logic [W-1:0] e_fw;
    n = mq.size();
    e_full  = (n == D);
    e_empty = (n == 0);
    e_af = (n >= int'(af_level)) && !e_full;
    e_ae = (n <= int'(ae_level)) && !e_empty;
    e_fw = e_empty ? '0 : mq[0];
    chk("m_count", 32'(b0.count), 32'(n));
    chk("m_full", 32'(b0.full), 32'(e_full));
    chk("m_empty", 32'(b0.empty), 32'(e_empty));
    chk("m_af", 32'(b0.almostfull), 32'(e_af));
    chk("m_ae", 32'(b0.almostempty), 32'(e_ae));
    chk("m_ack", 32'(b0.wr_ack), 32'(m_ack));
    chk("m_ovf", 32'(b0.overflow), 32'(m_ovf));
    chk("m_udf", 32'(b0.underflow), 32'(m_udf));
    chk("m_dout_std", 32'(b0.data_out), 32'(m_dout));
    chk("m_count_fw", 32'(b1.count), 32'(n));
    chk("m_ack_fw", 32'(b1.wr_ack), 32'(m_ack));
    chk("m_udf_fw", 32'(b1.underflow), 32'(m_udf));
    chk("m_dout_fw", 32'(b1.data_out), 32'(e_fw));
  end

  // Apply one cycle of requests at posedge+1, return at the next posedge+1.
  task automatic step(input logic we, input logic [W-1:0] d, input logic re, input logic fl);
    wr_en = we; data_in = d; rd_en = re; flush = fl;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_count", 32'(b0.count), 0);
    chk("rst_empty", 32'(b0.empty), 1);
    chk("rst_full", 32'(b0.full), 0);
    chk("rst_af", 32'(b0.almostfull), 0);
    chk("rst_ae", 32'(b0.almostempty), 0);
    chk("rst_dout", 32'(b0.data_out), 0);
    chk("rst_ack", 32'(b0.wr_ack), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: fill to full, then overflow
    for (int i = 0; i < 6; i++) begin
      step(1'b1, W'(16'h1001 + i), 1'b0, 1'b0);
      chk("t1_ack", 32'(b0.wr_ack), 1);
      chk("t1_count", 32'(b0.count), 32'(i + 1));
      if (i == 4) chk("t1_af5", 32'(b0.almostfull), 1);
    end
    chk("t1_full", 32'(b0.full), 1);
    chk("t1_af_at_full", 32'(b0.almostfull), 0);
    step(1'b1, 16'h1007, 1'b0, 1'b0);
    chk("t1_ovf", 32'(b0.overflow), 1);
    chk("t1_noack", 32'(b0.wr_ack), 0);
    chk("t1_count6", 32'(b0.count), 6);

    // 2: drain with underflow
    for (int k = 0; k < 6; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("t2_dout", 32'(b0.data_out), 32'(16'h1001 + k));
      chk("t2_count", 32'(b0.count), 32'(5 - k));
      chk("t2_fw_dout", 32'(b1.data_out), (k < 5) ? 32'(16'h1002 + k) : 32'h0);
      if (k == 4) chk("t2_ae1", 32'(b0.almostempty), 1);
    end
    chk("t2_empty", 32'(b0.empty), 1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t2_udf", 32'(b0.underflow), 1);
    chk("t2_hold", 32'(b0.data_out), 32'h1006);

    // 3: simultaneous read/write at full, then at empty
    for (int i = 0; i < 6; i++) step(1'b1, W'(16'h3001 + i), 1'b0, 1'b0);
    step(1'b1, 16'h2000, 1'b1, 1'b0);
    chk("t3_ack", 32'(b0.wr_ack), 1);
    chk("t3_noovf", 32'(b0.overflow), 0);
    chk("t3_count", 32'(b0.count), 6);
    chk("t3_dout", 32'(b0.data_out), 32'h3001);
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1, 1'b0);
    chk("t3_last", 32'(b0.data_out), 32'h2000);
    step(1'b1, 16'h4444, 1'b1, 1'b0);
    chk("t3_e_ack", 32'(b0.wr_ack), 1);
    chk("t3_e_udf", 32'(b0.underflow), 1);
    chk("t3_e_count", 32'(b0.count), 1);
    chk("t3_e_fw", 32'(b1.data_out), 32'h4444);

    // 4: FWFT fall-through
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t4_empty0", 32'(b1.empty), 1);
    step(1'b1, 16'hABCD, 1'b0, 1'b0);
    chk("t4_fw", 32'(b1.data_out), 32'hABCD);
    chk("t4_nempty", 32'(b1.empty), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t4_empty", 32'(b1.empty), 1);
    chk("t4_fw0", 32'(b1.data_out), 0);
    chk("t4_std", 32'(b0.data_out), 32'hABCD);

    // 5: flush, threshold change, async reset
    for (int i = 0; i < 4; i++) step(1'b1, W'(16'h5001 + i), 1'b0, 1'b0);
    chk("t5_c4", 32'(b0.count), 4);
    step(1'b1, 16'h5555, 1'b0, 1'b1);
    chk("t5_fl_count", 32'(b0.count), 0);
    chk("t5_fl_empty", 32'(b0.empty), 1);
    chk("t5_fl_ack", 32'(b0.wr_ack), 0);
    chk("t5_fl_std", 32'(b0.data_out), 32'hABCD);
    chk("t5_fl_fw", 32'(b1.data_out), 0);
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'h6001 + i), 1'b0, 1'b0);
    chk("t5_af_pre", 32'(b0.almostfull), 0);
    af_level = CW'(3);
    #1;
    chk("t5_af_post", 32'(b0.almostfull), 1);
    wr_en = 1'b1; data_in = 16'h7777;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_r_count", 32'(b0.count), 0);
    chk("t5_r_empty", 32'(b0.empty), 1);
    chk("t5_r_af", 32'(b0.almostfull), 0);
    chk("t5_r_ack", 32'(b0.wr_ack), 0);
    chk("t5_r_dout", 32'(b0.data_out), 0);
    chk("t5_r_fw", 32'(b1.data_out), 0);
    wr_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    af_level = CW'(5);
    step(1'b1, 16'h8001, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t5_after", 32'(b0.data_out), 32'h8001);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
- Parametrised single-clock synchronous FIFO. Next generation of the team's FIFO.
- Adds several features:
  - arbitrary (non-power-of-two) depth
  - runtime-programmable almost-full/almost-empty levels
  - occupancy count output
  - synchronous flush
  - selectable standard or first-word-fall-through (FWFT) read mode
- Used as the generic buffering primitive between producer/consumer blocks in the same clock domain.

Parameters:
- FIFO_WIDTH, 16, data word width in bits (≥1).
- FIFO_DEPTH, 8, number of storage entries (≥2, need not be a power of two).
- FWFT, 0, read mode: 0 = standard (registered read data), 1 = first-word-fall-through.
- CNT_W, $clog2(FIFO_DEPTH+1), width of the count and level signals (derived; not overridden).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- data_in  in  FIFO_WIDTH  write data.
- rd_en  in  1  read request (FWFT=1: pop the head word).
- af_level  in  CNT_W  almost-full threshold.
- ae_level  in  CNT_W  almost-empty threshold.
- data_out  out  FIFO_WIDTH  read data.
- count  out  CNT_W  current occupancy, 0..FIFO_DEPTH.
- full, almostfull, empty, almostempty  out  1 each  status flags.
- wr_ack, overflow, underflow  out  1 each  registered handshake pulses.

Behaviour:
- **Reset (rst_n=0, async):**
  - pointers and count = 0
  - data_out = 0
  - wr_ack = overflow = underflow = 0
  - empty = 1; full = almostfull = almostempty = 0
- **Storage:** FIFO_DEPTH-entry array. wr_ptr and rd_ptr advance by 1 and wrap from FIFO_DEPTH-1 to 0 explicitly; never rely on power-of-two rollover.
- **Write acceptance:** wr_acc = wr_en & (!full | rd_acc).
  - A write into a full FIFO is accepted only when a read is accepted in the same cycle.
- **Read acceptance:** rd_acc = rd_en & !empty.
  - Reads are based on the registered occupancy only, so there is no same-cycle write-to-read bypass when empty.
- **Count update:** count_next = count + wr_acc − rd_acc. Both accepted → count unchanged and both pointers advance.
- **Flags:** combinational from the registered count.
  - full = (count == FIFO_DEPTH)
  - empty = (count == 0)
  - almostfull = (count >= af_level) & !full
  - almostempty = (count <= ae_level) & !empty
  - af_level/ae_level are sampled continuously; changing them retimes the flags immediately with no pointer effect.
  - af_level = 0 → almostfull = !full. ae_level ≥ FIFO_DEPTH → almostempty = !empty.
- **Handshake pulses:** registered, valid the cycle after the request edge, high for exactly one cycle per request cycle.
  - wr_ack = wr_acc
  - overflow = wr_en & !wr_acc
  - underflow = rd_en & !rd_acc
- **FWFT=0 (standard mode):**
  - On rd_acc, data_out <= mem[rd_ptr], valid the cycle after the rd_en edge.
  - Otherwise data_out holds its last value, including on underflow.
- **FWFT=1:**
  - data_out = mem[rd_ptr] continuously while !empty; 0 while empty.
  - rd_acc advances to the next word.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- **Flush (synchronous, highest priority after reset):**
  - pointers and count = 0
  - wr_en/rd_en in that cycle are ignored
  - wr_ack, overflow and underflow are all 0 the next cycle
  - data_out: holds in FWFT=0; reads 0 in FWFT=1
- **Reset mid-operation:** immediate clear on the rst_n fall; stored contents are discarded.
- **Data integrity:** strict order, no loss or duplication, for any interleaving of writes and reads.

Test Plan:
All scenarios use FIFO_WIDTH=16, FIFO_DEPTH=6, af_level=5, ae_level=1.
1. **Fill to full and overflow:** write 0x1001..0x1006 on 6 consecutive cycles, then 0x1007 with rd_en=0.
   - 6 wr_ack pulses.
   - almostfull=1 at count=5; full=1 at count=6.
   - overflow=1 for the 7th write; count stays 6.
   - Pointer wrap is exercised (depth not a power of 2).
2. **Drain and underflow, FWFT=0:** from full, assert rd_en for 7 cycles.
   - data_out = 0x1001..0x1006, each one cycle after its rd_en edge.
   - almostempty=1 at count=1; empty=1 at count=0.
   - Underflow on the 7th read; data_out holds 0x1006.
3. **Simultaneous read/write at full:** from full, assert wr_en=1 (0x2000) and rd_en=1 together.
   - wr_ack=1 and overflow=0; count stays 6.
   - 0x2000 is read out last.
   - At empty, both asserted → write accepted, underflow=1, count=1.
4. **FWFT=1:** write 0xABCD into an empty FIFO.
   - data_out=0xABCD and empty=0 the next cycle, with no rd_en.
   - A single rd_en pulse → empty=1 and data_out=0.
5. **Flush, reset and threshold change:** with count=4, assert flush together with wr_en.
   - Next cycle: count=0, empty=1, wr_ack=0.
   - Refill to 3, then change af_level to 3 → almostfull rises the same cycle.
   - Drop rst_n asynchronously mid-write → all outputs return to reset values before the next clock edge.
